clksel_seq: RTL
===============

# clksel_seq

Clock-select sequencer that decides when the CPU must run on the slow host clock and drives the clock controller's select input. It decodes each CPU cycle's address to tell host-bus accesses (memory-mapped IO, forced-slow) from local fast-RAM accesses. It performs the select/acknowledge handshake with the clock controller, holding CPU RDY low while a switch is in flight. It runs entirely on the fast clock and synchronizes the controller's selected-clock feedback.

## Interface

- SLOW_LO, 16'hFC00: lowest bank-0 address requiring the slow clock.
- SLOW_HI, 16'hFEFF: highest bank-0 address requiring the slow clock.
- HOLD_CYCLES, 8: fast-region CPU cycles that must pass in SLOW before switching back (hysteresis).
- CNT_W, 4: hysteresis counter width; HOLD_CYCLES < 2^CNT_W.
- TIMEOUT, 255: hsclk_in cycles allowed for a handshake before flagging an error.
- TO_W, 8: timeout counter width.

- hsclk_in  in  1  fast clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_strobe  in  1  one-cycle pulse per CPU cycle, when cpu_addr is valid.
- cpu_addr  in  24  CPU address (bank in [23:16]).
- force_slow  in  1  treat the current access as slow regardless of address (host ROM, shadow off).
- hsclk_selected  in  1  controller feedback, asynchronous to hsclk_in.
- lsclk_selected  in  1  controller feedback, asynchronous to hsclk_in.
- hsclk_sel  out  1  request to controller: 1 selects the fast clock.
- cpu_rdy  out  1  CPU RDY; 0 stalls the CPU.
- in_slow  out  1  high in SLOW, TO_SLOW and TO_FAST.
- sw_err  out  1  sticky handshake-timeout flag; cleared only by rst.

## Operation

- slow_acc = force_slow | (cpu_addr[23:16]==0 & SLOW_LO <= cpu_addr[15:0] <= SLOW_HI).
- hs_ack and ls_ack are 2-FF synchronized copies of hsclk_selected and lsclk_selected.
- The sequencer has four states. hsclk_sel is 1 in FAST and TO_FAST, and 0 in SLOW and TO_SLOW.
  - FAST: on cpu_strobe & slow_acc, go to TO_SLOW.
  - TO_SLOW: wait for ls_ack=1 & hs_ack=0, then go to SLOW.
  - SLOW: on cpu_strobe & slow_acc, reload hold_cnt to HOLD_CYCLES. On cpu_strobe & !slow_acc:
    - if hold_cnt==0, go to TO_FAST;
    - otherwise decrement hold_cnt.
  - TO_FAST: wait for hs_ack=1 & ls_ack=0, then go to FAST.
- cpu_rdy = 0 in TO_SLOW and TO_FAST. It is also forced to 0 combinationally in the strobe cycle that triggers FAST->TO_SLOW, so the CPU never completes a slow access at fast speed.
- The SLOW->TO_FAST trigger does not stall the current cycle, because a fast access at slow speed is legal. cpu_rdy is 0 from the next cycle until FAST is reached.
- Timeout counter:
  - cleared on entry to TO_SLOW or TO_FAST; increments each cycle in those states;
  - on reaching TIMEOUT, sets sw_err and forces the pending state's target (SLOW or FAST) so the CPU cannot deadlock.
  - It saturates and does not wrap.
- hold_cnt saturates at 0. A slow access arriving while hold_cnt==0 reloads it, with no switch.
- A strobe during TO_SLOW or TO_FAST is ignored; the CPU is stalled, and the same address re-strobes after release.

## Timing

- Reset values:
  - state SLOW; hsclk_sel 0; cpu_rdy 1; in_slow 1; sw_err 0;
  - hold_cnt HOLD_CYCLES; timeout counter 0; synchronizers 0.
- Boot therefore runs slow for at least HOLD_CYCLES+1 fast-region cycles.
- hsclk_sel changes on the clock edge after the triggering strobe edge.
- Switch latency is 2 synchronizer cycles plus controller latency. The minimum stall is 3 hsclk_in cycles after the trigger edge.
- rst asserted mid-handshake returns to the reset state immediately. The controller must also be in reset, or must follow hsclk_sel=0.

## Configuration

- CLKSEL_HYSTERESIS_EN:
  - defined: hold_cnt and HOLD_CYCLES behave as above.
  - undefined: hold_cnt is removed, and the first cpu_strobe & !slow_acc in SLOW (and out of reset) goes to TO_FAST.

## Structure

- Package clksel_pkg holds:
  - the state enum (FAST, TO_SLOW, SLOW, TO_FAST; 2-bit encoding);
  - default SLOW_LO and SLOW_HI constants;
  - the slow-region decode function.
- One sub-module, sync2, is a 2-FF bit synchronizer with async active-high reset to 0. It is instantiated twice.

## Test plan

- Reset, then controller model acks ls after 2 cycles; strobe 20 fast accesses (cpu_addr=24'h002000) -> stays SLOW for 8 strobes, TO_FAST on the 9th, hsclk_sel=1, cpu_rdy low until hs_ack, then FAST.
- In FAST, strobe cpu_addr=24'h00FE40 -> cpu_rdy=0 in the same cycle, hsclk_sel=0 on the next edge, SLOW after ls ack with a 4-cycle model delay, cpu_rdy=1.
- In SLOW with hold_cnt=3, strobe 24'h00FC00 -> hold_cnt=8 and no switch; cpu_addr=24'h01FE40 with force_slow=0 -> counts as fast.
- Controller model never acks during TO_FAST -> after 255 cycles sw_err=1, state FAST, cpu_rdy=1; sw_err stays set until rst.
- Assert rst during TO_SLOW -> hsclk_sel=0, cpu_rdy=1, state SLOW immediately; synchronizers cleared.
- Build without CLKSEL_HYSTERESIS_EN: in SLOW, one fast strobe -> TO_FAST immediately.

Source files
------------

// File: rtl/clksel_pkg.sv
// Shared types and helpers for the clock-select sequencer: state encoding,
// default slow-window bounds and the host-bus address decode.
package clksel_pkg;

  typedef enum logic [1:0] {
    FAST    = 2'd0,
    TO_SLOW = 2'd1,
    SLOW    = 2'd2,
    TO_FAST = 2'd3
  } state_e;

  localparam logic [15:0] SLOW_LO_DEF = 16'hFC00;
  localparam logic [15:0] SLOW_HI_DEF = 16'hFEFF;

  // Bank 0 IO window or an externally forced slow access.
  function automatic logic slow_decode(input logic [23:0] addr, input logic force_slow,
                                       input logic [15:0] lo, input logic [15:0] hi);
    return force_slow | ((addr[23:16] == 8'h00) && (addr[15:0] >= lo) && (addr[15:0] <= hi));
  endfunction

endpackage

// File: rtl/clksel_seq_sync2.sv
// Two-flop bit synchronizer, async active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clksel_seq.sv
// Clock-select sequencer: decodes CPU accesses, handshakes hsclk_sel with the
// clock controller and stalls the CPU while a switch is in flight.
// Optional hysteresis counter enabled by `define CLKSEL_HYSTERESIS_EN.
module clksel_seq import clksel_pkg::*; #(
  parameter logic [15:0] SLOW_LO = SLOW_LO_DEF,
  parameter logic [15:0] SLOW_HI = SLOW_HI_DEF,
`ifdef CLKSEL_HYSTERESIS_EN
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4,
`endif
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic        hsclk_in,
  input  logic        rst,
  input  logic        cpu_strobe,
  input  logic [23:0] cpu_addr,
  input  logic        force_slow,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  output logic        hsclk_sel,
  output logic        cpu_rdy,
  output logic        in_slow,
  output logic        sw_err
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_e          state, state_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            err_nx;
  logic            hs_ack, ls_ack;
  logic            slow_acc, slow_stb, fast_stb, hold_done;

  sync2 u_sync_hs (.clk(hsclk_in), .rst(rst), .d(hsclk_selected), .q(hs_ack));
  sync2 u_sync_ls (.clk(hsclk_in), .rst(rst), .d(lsclk_selected), .q(ls_ack));

  assign slow_acc = slow_decode(cpu_addr, force_slow, SLOW_LO, SLOW_HI);
  assign slow_stb = cpu_strobe & slow_acc;
  assign fast_stb = cpu_strobe & ~slow_acc;

`ifdef CLKSEL_HYSTERESIS_EN
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  logic [CNT_W-1:0] hold_cnt;

  assign hold_done = (hold_cnt == '0);

  // Held at HOLD outside SLOW so every entry to SLOW starts a fresh window.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst)                            hold_cnt <= HOLD;
    else if (state != SLOW || slow_stb) hold_cnt <= HOLD;
    else if (fast_stb && !hold_done)    hold_cnt <= hold_cnt - 1'b1;
  end
`else
  assign hold_done = 1'b1;
`endif

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state  <= SLOW;
      to_cnt <= '0;
      sw_err <= 1'b0;
    end else begin
      state  <= state_nx;
      to_cnt <= to_cnt_nx;
      sw_err <= err_nx;
    end
  end

  // Timeout forces the pending target so a silent controller cannot hang the CPU.
  always_comb begin
    state_nx  = state;
    to_cnt_nx = to_cnt;
    err_nx    = sw_err;
    unique case (state)
      FAST: if (slow_stb) begin
        state_nx  = TO_SLOW;
        to_cnt_nx = '0;
      end
      TO_SLOW: begin
        if (ls_ack && !hs_ack) state_nx = SLOW;
        else if (to_cnt == TO_MAX) begin
          state_nx = SLOW;
          err_nx   = 1'b1;
        end else to_cnt_nx = to_cnt + 1'b1;
      end
      SLOW: if (fast_stb && hold_done) begin
        state_nx  = TO_FAST;
        to_cnt_nx = '0;
      end
      TO_FAST: begin
        if (hs_ack && !ls_ack) state_nx = FAST;
        else if (to_cnt == TO_MAX) begin
          state_nx = FAST;
          err_nx   = 1'b1;
        end else to_cnt_nx = to_cnt + 1'b1;
      end
    endcase
  end

  assign hsclk_sel = (state == FAST) || (state == TO_FAST);
  assign in_slow   = (state != FAST);
  // A slow access seen in FAST must not complete at fast speed.
  assign cpu_rdy   = !((state == TO_SLOW) || (state == TO_FAST)) && !((state == FAST) && slow_stb);

endmodule
